reg_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single memory port between NREQ register-manager requesters. Each requester issues one-cycle read/write pulses with address and data. The arbiter latches every request into a per-requester slot and serializes the slots onto a request/acknowledge memory interface. It then broadcasts completion as a busy/done strobe with the address and data, which each requester matches against its own address. It sits between the per-CPU register managers and main memory, and it is the only driver of the shared bus-busy and done signals.

---
 rtl/reg_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter serializing per-requester slots onto one memory port
module reg_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          rd_q,
  input  logic [NREQ-1:0]          wr_q,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic                     bus_busy,
  output logic                     rd_dn,
  output logic                     wr_dn,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  output logic [IDW-1:0]           grant_id,
  output logic                     timeout_err,
  output logic                     drop_err,
  input  logic                     err_clr
);
  localparam logic [7:0]     TMO      = 8'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_d;
  logic [NREQ-1:0] pend, pend_d, op_s, pulse, clr_mask;
  logic [ADDR_W-1:0] addr_s [NREQ];
  logic [DATA_W-1:0] data_s [NREQ];
  logic [IDW-1:0] last, last_d, gnt_d, win, idx;
  logic [7:0] cnt, cnt_d;
  logic found, to_hit, req_d, we_d, busy_d, rdn_d, wdn_d;
  logic [ADDR_W-1:0] maddr_d, baddr_d;
  logic [DATA_W-1:0] mwdata_d, bdata_d;
  assign pulse    = rd_q | wr_q;
  assign clr_mask = (state == DONE) ? (NREQ'(1) << grant_id) : '0;
  assign pend_d   = (pend & ~clr_mask) | (pulse & ~pend);
  // round-robin search starting one past the previous winner
  always_comb begin
    win = last;
    found = 1'b0;
    idx = last;
    for (int j = 0; j < NREQ; j++) begin
      idx = (idx == LAST_RST) ? '0 : idx + 1'b1;
      if (!found && pend[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // next state and next registered output values
  always_comb begin
    state_d = state;
    last_d = last;
    gnt_d = grant_id;
    cnt_d = cnt;
    req_d = 1'b0;
    we_d = 1'b0;
    maddr_d = '0;
    mwdata_d = '0;
    busy_d = 1'b0;
    rdn_d = 1'b0;
    wdn_d = 1'b0;
    baddr_d = '0;
    bdata_d = '0;
    to_hit = 1'b0;
    if (state == IDLE && |pend) begin
      state_d = ISSUE;
      last_d = win;
      gnt_d = win;
      cnt_d = '0;
      req_d = 1'b1;
      we_d = op_s[win];
      maddr_d = addr_s[win];
      mwdata_d = data_s[win];
      busy_d = 1'b1;
    end else if (state == ISSUE) begin
      busy_d = 1'b1;
      if (mem_ack || cnt == TMO) begin
        state_d = DONE;
        to_hit = !mem_ack;
        rdn_d = !op_s[grant_id];
        wdn_d = op_s[grant_id];
        baddr_d = addr_s[grant_id];
        bdata_d = op_s[grant_id] ? data_s[grant_id] : (mem_ack ? mem_rdata : '0);
      end else begin
        cnt_d = cnt + 8'd1;
        req_d = 1'b1;
        we_d = mem_we;
        maddr_d = mem_addr;
        mwdata_d = mem_wdata;
      end
    end else if (state == DONE) begin
      state_d = IDLE;
    end
  end
  // control state and all outputs, async cleared; err_clr beats a same-cycle set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pend <= '0;
      last <= LAST_RST;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      bus_busy <= 1'b0;
      rd_dn <= 1'b0;
      wr_dn <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_d;
      pend <= pend_d;
      last <= last_d;
      cnt <= cnt_d;
      mem_req <= req_d;
      mem_we <= we_d;
      mem_addr <= maddr_d;
      mem_wdata <= mwdata_d;
      bus_busy <= busy_d;
      rd_dn <= rdn_d;
      wr_dn <= wdn_d;
      bus_addr <= baddr_d;
      bus_data <= bdata_d;
      grant_id <= gnt_d;
      timeout_err <= err_clr ? 1'b0 : (timeout_err | to_hit);
      drop_err <= err_clr ? 1'b0 : (drop_err | (|(pulse & pend)));
    end
  end
  // slot payload loads only into empty slots; write wins over a same-cycle read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (pulse[i] && !pend[i]) begin
        op_s[i] <= wr_q[i];
        addr_s[i] <= req_addr[i*ADDR_W +: ADDR_W];
        data_s[i] <= req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: table vectors plus hand sequences, done strobes checked against a scoreboard
module tb_reg_bus_arbiter;
  logic clk, rst, mem_req, mem_we, mem_ack, bus_busy, rd_dn, wr_dn, timeout_err, drop_err, err_clr;
  logic [3:0] rd_q, wr_q;
  logic [127:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, bus_addr, bus_data;
  logic [1:0] grant_id;
  typedef struct packed {logic [1:0] id; logic we; logic [31:0] addr; logic [31:0] data; logic [15:0] gap;} exp_t;
  typedef struct packed {logic [3:0] rd; logic [3:0] wr; logic [3:0] dly; logic [2:0] n; logic [7:0] ord;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];
  int checks = 0, errors = 0, cyc = 0, last_dn = 0, ack_dly = 0, n = 0;
  int nreq, nbusy, nwdn;
  logic no_ack = 1'b0, use_fix = 1'b0;
  logic [31:0] fix_data = '0, a;
  logic [1:0] gid_e;

  reg_bus_arbiter dut (
    .clk(clk), .rst(rst), .rd_q(rd_q), .wr_q(wr_q), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_busy(bus_busy), .rd_dn(rd_dn), .wr_dn(wr_dn),
    .bus_addr(bus_addr), .bus_data(bus_data), .grant_id(grant_id), .timeout_err(timeout_err),
    .drop_err(drop_err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;

  function automatic logic [31:0] addr_of(input int v, input int i);
    return (32'(v + 1) << 12) | (32'(i) << 4);
  endfunction
  function automatic logic [31:0] wdata_of(input int v, input int i);
    return 32'hC0DE_0000 ^ addr_of(v, i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic we, input logic [31:0] ad, input logic [31:0] d, input int gap);
    sb.push_back('{id: id, we: we, addr: ad, data: d, gap: 16'(gap)});
  endtask

  task automatic set_bus(input int v);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = addr_of(v, i);
      req_wdata[i*32 +: 32] = wdata_of(v, i);
    end
  endtask

  task automatic pulse(input logic [3:0] rd, input logic [3:0] wr, input int v, input logic clr);
    @(negedge clk);
    rd_q = rd;
    wr_q = wr;
    err_clr = clr;
    set_bus(v);
    @(negedge clk);
    rd_q = '0;
    wr_q = '0;
    err_clr = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  // memory model: ack after ack_dly ISSUE cycles, read data is the inverted address
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack = !no_ack && (n == ack_dly);
        mem_rdata = use_fix ? fix_data : ~mem_addr;
        n++;
      end else begin
        mem_ack = 1'b0;
        n = 0;
      end
    end
  end

  // done-strobe monitor against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rd_dn || wr_dn) begin
      chk("dn_excl", 32'(rd_dn & wr_dn), 0);
      chk("dn_busy", 32'(bus_busy), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got id %0d addr %h expected no done", grant_id, bus_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("grant_id", 32'(grant_id), 32'(mon_e.id));
        chk("done_we", 32'(wr_dn), 32'(mon_e.we));
        chk("bus_addr", bus_addr, mon_e.addr);
        chk("bus_data", bus_data, mon_e.data);
        if (mon_e.gap != 0) chk("done_gap", 32'(cyc - last_dn), 32'(mon_e.gap));
      end
      last_dn = cyc;
    end
  end

  initial begin
    rst = 1'b0;
    rd_q = '0;
    wr_q = '0;
    req_addr = '0;
    req_wdata = '0;
    err_clr = 1'b0;
    vt[0] = '{rd: 4'b1001, wr: 4'b0100, dly: 4'd0, n: 3'd3, ord: {2'd0, 2'd3, 2'd2, 2'd0}};
    vt[1] = '{rd: 4'b0001, wr: 4'b0000, dly: 4'd0, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd0}};
    vt[2] = '{rd: 4'b0011, wr: 4'b0000, dly: 4'd0, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd1}};
    vt[3] = '{rd: 4'b0000, wr: 4'b1111, dly: 4'd0, n: 3'd4, ord: {2'd0, 2'd3, 2'd2, 2'd1}};
    vt[4] = '{rd: 4'b0110, wr: 4'b0110, dly: 4'd0, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd1}};
    vt[5] = '{rd: 4'b1011, wr: 4'b0000, dly: 4'd2, n: 3'd3, ord: {2'd0, 2'd1, 2'd0, 2'd3}};
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(bus_busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_bus_addr", bus_addr, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_mem_addr", mem_addr, 0);
    for (int v = 0; v < 6; v++) begin
      ack_dly = int'(vt[v].dly);
      for (int j = 0; j < int'(vt[v].n); j++) begin
        gid_e = vt[v].ord[2*j +: 2];
        a = addr_of(v, int'(gid_e));
        push(gid_e, vt[v].wr[gid_e], a, vt[v].wr[gid_e] ? wdata_of(v, int'(gid_e)) : ~a, j == 0 ? 0 : 3 + ack_dly);
      end
      pulse(vt[v].rd, vt[v].wr, v, 1'b0);
      drain();
    end
    ack_dly = 0;
    use_fix = 1'b1;
    fix_data = 32'hDEAD_BEEF;
    push(2'd1, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    pulse(4'b0010, 4'b0000, -1, 1'b0);
    @(negedge clk);
    chk("sr_mem_req", 32'(mem_req), 1);
    chk("sr_mem_addr", mem_addr, 32'h10);
    chk("sr_mem_we", 32'(mem_we), 0);
    chk("sr_grant", 32'(grant_id), 1);
    @(negedge clk);
    chk("sr_rd_dn", 32'(rd_dn), 1);
    chk("sr_req_off", 32'(mem_req), 0);
    @(negedge clk);
    chk("sr_dn_off", 32'(rd_dn), 0);
    chk("sr_busy_off", 32'(bus_busy), 0);
    chk("sr_bus_data_zero", bus_data, 0);
    chk("sr_grant_hold", 32'(grant_id), 1);
    drain();
    use_fix = 1'b0;
    ack_dly = 5;
    push(2'd2, 1'b1, addr_of(12, 2), wdata_of(12, 2), 0);
    pulse(4'b0000, 4'b0100, 12, 1'b0);
    nreq = 0;
    nbusy = 0;
    nwdn = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      nreq += int'(mem_req);
      nbusy += int'(bus_busy);
      nwdn += int'(wr_dn);
    end
    chk("dly_req_cycles", 32'(nreq), 6);
    chk("dly_busy_cycles", 32'(nbusy), 7);
    chk("dly_wr_dn_pulses", 32'(nwdn), 1);
    drain();
    ack_dly = 0;
    no_ack = 1'b1;
    push(2'd3, 1'b0, addr_of(13, 3), 32'h0, 0);
    pulse(4'b1000, 4'b0000, 13, 1'b0);
    nreq = 0;
    for (int t = 0; t < 270; t++) begin
      @(negedge clk);
      nreq += int'(mem_req);
    end
    no_ack = 1'b0;
    chk("to_req_cycles", 32'(nreq), 256);
    chk("to_err_set", 32'(timeout_err), 1);
    drain();
    pulse(4'b0000, 4'b0000, 0, 1'b1);
    chk("to_err_clr", 32'(timeout_err), 0);
    a = addr_of(14, 1);
    push(2'd1, 1'b0, a, ~a, 0);
    @(negedge clk);
    set_bus(14);
    rd_q = 4'b0010;
    @(negedge clk);
    set_bus(15);
    @(negedge clk);
    rd_q = '0;
    chk("drop_set", 32'(drop_err), 1);
    chk("drop_first_addr", mem_addr, a);
    @(negedge clk);
    set_bus(16);
    rd_q = 4'b0010;
    err_clr = 1'b1;
    @(negedge clk);
    rd_q = '0;
    err_clr = 1'b0;
    chk("drop_clr_priority", 32'(drop_err), 0);
    repeat (6) @(negedge clk);
    drain();
    no_ack = 1'b1;
    pulse(4'b0001, 4'b0000, 17, 1'b0);
    @(negedge clk);
    chk("rst_mid_req", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 0);
    chk("rst_async_busy", 32'(bus_busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    no_ack = 1'b0;
    nreq = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      nreq += int'(mem_req);
    end
    chk("rst_pend_cleared", 32'(nreq), 0);
    a = addr_of(18, 0);
    push(2'd0, 1'b0, a, ~a, 0);
    a = addr_of(18, 2);
    push(2'd2, 1'b0, a, ~a, 3);
    pulse(4'b0101, 4'b0000, 18, 1'b0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
